// File: rtl/iterative_mul14_seq.sv
// Sequencer for a 2*HW x 2*HW unsigned multiply built from four passes
// through one shared HW x HW multiplier, accumulating shifted partial products.
module iterative_mul14_seq #(
    parameter int HW = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*HW-1:0]   in_a,
    input  logic [2*HW-1:0]   in_b,
    output logic              mul_en,
    output logic [HW-1:0]     mul_a,
    output logic [HW-1:0]     mul_b,
    input  logic [2*HW-1:0]   mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*HW-1:0]   out_p,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_step;
    logic [2*HW-1:0]     r_a;
    logic [2*HW-1:0]     r_b;
    logic [4*HW-1:0]     r_acc;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_mul_en;
    logic [HW-1:0]       r_mul_a;
    logic [HW-1:0]       r_mul_b;
    logic                r_busy;

    state_t              w_state_nx;
    logic [1:0]          w_step_nx;
    logic [2*HW-1:0]     w_a_nx;
    logic [2*HW-1:0]     w_b_nx;
    logic [4*HW-1:0]     w_acc_nx;
    logic                w_in_ready_nx;
    logic                w_out_valid_nx;
    logic                w_mul_en_nx;
    logic [2*HW-1:0]     w_ops_nx;

    // Half-operand pair {a_half, b_half} fed to the shared multiplier for a step.
    function automatic logic [2*HW-1:0] sel_ops(input logic [1:0] step,
                                                input logic [2*HW-1:0] a,
                                                input logic [2*HW-1:0] b);
        case (step)
            2'd0:    sel_ops = {a[HW-1:0],    b[HW-1:0]};
            2'd1:    sel_ops = {a[HW-1:0],    b[2*HW-1:HW]};
            2'd2:    sel_ops = {a[2*HW-1:HW], b[HW-1:0]};
            2'd3:    sel_ops = {a[2*HW-1:HW], b[2*HW-1:HW]};
            default: sel_ops = '0;
        endcase
    endfunction

    // Partial product weighted by the significance of the halves used in a step.
    function automatic logic [4*HW-1:0] shift_pp(input logic [1:0] step,
                                                 input logic [2*HW-1:0] p);
        logic [4*HW-1:0] ext;
        ext = {{(2*HW){1'b0}}, p};
        case (step)
            2'd0:       shift_pp = ext;
            2'd1, 2'd2: shift_pp = ext << HW;
            2'd3:       shift_pp = ext << (2*HW);
            default:    shift_pp = '0;
        endcase
    endfunction

    // Next-state and next-output decode; outputs are precomputed for the coming cycle.
    always_comb begin
        w_state_nx     = r_state;
        w_step_nx      = r_step;
        w_a_nx         = r_a;
        w_b_nx         = r_b;
        w_acc_nx       = r_acc;
        w_in_ready_nx  = 1'b0;
        w_out_valid_nx = 1'b0;
        w_mul_en_nx    = 1'b0;
        w_ops_nx       = '0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nx  = S_RUN;
                    w_step_nx   = 2'd0;
                    w_a_nx      = in_a;
                    w_b_nx      = in_b;
                    w_acc_nx    = '0;
                    w_mul_en_nx = 1'b1;
                    w_ops_nx    = sel_ops(2'd0, in_a, in_b);
                end else begin
                    w_in_ready_nx = 1'b1;
                end
            end
            S_RUN: begin
                w_acc_nx = r_acc + shift_pp(r_step, mul_p);
                if (r_step == 2'd3) begin
                    w_state_nx     = S_DONE;
                    w_out_valid_nx = 1'b1;
                end else begin
                    w_step_nx   = r_step + 2'd1;
                    w_mul_en_nx = 1'b1;
                    w_ops_nx    = sel_ops(r_step + 2'd1, r_a, r_b);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nx    = S_IDLE;
                    w_in_ready_nx = 1'b1;
                end else begin
                    w_out_valid_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx    = S_IDLE;
                w_in_ready_nx = 1'b1;
            end
        endcase
    end

    // State, datapath and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_step      <= 2'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mul_en    <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_step      <= w_step_nx;
            r_a         <= w_a_nx;
            r_b         <= w_b_nx;
            r_acc       <= w_acc_nx;
            r_in_ready  <= w_in_ready_nx;
            r_out_valid <= w_out_valid_nx;
            r_mul_en    <= w_mul_en_nx;
            r_mul_a     <= w_ops_nx[2*HW-1:HW];
            r_mul_b     <= w_ops_nx[HW-1:0];
            r_busy      <= (w_state_nx != S_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_p     = r_acc;
    assign mul_en    = r_mul_en;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign busy      = r_busy;

endmodule
